// File: rtl/usbh_xfer_sched.sv
// USB host transfer scheduler: arbitrates two channels onto one SIE, retries NAK/errors, tracks data toggles.
// Latency: grant -> sie_start_o one cycle after request; done pulse in the EVAL cycle, IDLE follows.
// Backpressure: sie_start_o and all sie_* fields hold until sie_req_ack_i; losing channel waits for IDLE.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   chN_req/pid/token/in/len     channel N transfer request (held until chN_done_o)
//   chN_toggle_clr_i             force channel N data toggle to DATA0
//   chN_done_o, chN_status_o     completion pulse; status 00 OK, 01 STALL, 10 NAK limit, 11 error
//   sie_*_o                      transfer request to the SIE
//   sie_*_i                      SIE handshake and response status
//   busy_o                       scheduler not idle
module usbh_xfer_sched #(
  parameter int ERR_RETRIES = 3,
  parameter int NAK_RETRIES = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ch0_req_i,
  input  logic [7:0]  ch0_pid_i,
  input  logic [10:0] ch0_token_i,
  input  logic        ch0_in_i,
  input  logic [15:0] ch0_len_i,
  input  logic        ch0_toggle_clr_i,
  output logic        ch0_done_o,
  output logic [1:0]  ch0_status_o,
  input  logic        ch1_req_i,
  input  logic [7:0]  ch1_pid_i,
  input  logic [10:0] ch1_token_i,
  input  logic        ch1_in_i,
  input  logic [15:0] ch1_len_i,
  input  logic        ch1_toggle_clr_i,
  output logic        ch1_done_o,
  output logic [1:0]  ch1_status_o,
  output logic        sie_start_o,
  output logic [7:0]  sie_token_pid_o,
  output logic [10:0] sie_token_data_o,
  output logic [15:0] sie_tx_count_o,
  output logic        sie_data_idx_o,
  output logic        sie_in_transfer_o,
  output logic        sie_resp_expected_o,
  input  logic        sie_req_ack_i,
  input  logic        sie_tx_done_i,
  input  logic        sie_rx_done_i,
  input  logic        sie_rx_crc_err_i,
  input  logic        sie_rx_resp_timeout_i,
  input  logic [7:0]  sie_rx_resp_pid_i,
  input  logic        sie_sof_irq_i,
  output logic        busy_o
);

  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_EVAL, S_HOLDOFF} state_t;
  typedef enum logic [1:0] {R_OK, R_STALL, R_NAK, R_ERR} rsp_t;

  state_t      state_q, state_d;
  logic        cur_ch_q, last_ch_q;
  logic [1:0]  toggle_q;
  logic [3:0]  nak_cnt_q;
  logic [1:0]  err_cnt_q;
  logic [7:0]  rsp_pid_q;
  logic        rsp_err_q;
  logic        hold_arm_q;
  logic [1:0]  st0_q, st1_q;

  logic        grant, grant_ch, wait_done;
  rsp_t        rsp;
  logic        fin;
  logic [1:0]  fin_status;
  logic [4:0]  nak_next;
  logic [2:0]  err_next;
  logic        toggle_new;
  logic [1:0]  toggle_clr;

  // The SIE's tx-done strobe carries no scheduling information: only the
  // handshake response (or its timeout) ends a transfer.
  logic        unused_tx_done;
  assign unused_tx_done = sie_tx_done_i;

  assign toggle_clr = {ch1_toggle_clr_i, ch0_toggle_clr_i};
  assign wait_done  = sie_rx_done_i | sie_rx_resp_timeout_i;

  // Round-robin: on a tie the channel not served last wins.
  assign grant    = ch0_req_i | ch1_req_i;
  assign grant_ch = (ch0_req_i & ch1_req_i) ? ~last_ch_q : ch1_req_i;

  // Response classification works from values captured at WAIT completion,
  // so EVAL is independent of whatever the SIE drives afterwards.
  always_comb begin
    rsp = R_ERR;
    if (rsp_err_q)                                               rsp = R_ERR;
    else if (rsp_pid_q == PID_STALL)                             rsp = R_STALL;
    else if (rsp_pid_q == PID_NAK)                               rsp = R_NAK;
    else if (!sie_in_transfer_o && rsp_pid_q == PID_ACK)         rsp = R_OK;
    else if (sie_in_transfer_o &&
             (rsp_pid_q == PID_DATA0 || rsp_pid_q == PID_DATA1)) rsp = R_OK;
  end

  // Limits are judged on the incremented count in a wider type so a counter
  // sitting at its saturation value can still trip the limit.
  assign nak_next = {1'b0, nak_cnt_q} + 5'd1;
  assign err_next = {1'b0, err_cnt_q} + 3'd1;

  always_comb begin
    fin        = 1'b0;
    fin_status = 2'b00;
    case (rsp)
      R_OK:    begin fin = 1'b1;                          fin_status = 2'b00; end
      R_STALL: begin fin = 1'b1;                          fin_status = 2'b01; end
      R_NAK:   begin fin = int'(nak_next) > NAK_RETRIES;  fin_status = 2'b10; end
      default: begin fin = int'(err_next) > ERR_RETRIES;  fin_status = 2'b11; end
    endcase
  end

  // IN: next toggle is the opposite of the DATA PID received.
  assign toggle_new = sie_in_transfer_o ? (rsp_pid_q == PID_DATA0) : ~toggle_q[cur_ch_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (grant)         state_d = S_START;
      S_START:   if (sie_req_ack_i) state_d = S_WAIT;
      S_WAIT:    if (wait_done)     state_d = S_EVAL;
      S_EVAL: begin
        if (fin)                    state_d = S_IDLE;
        else if (rsp == R_NAK)      state_d = S_HOLDOFF;
        else                        state_d = S_START;
      end
      // An SOF coinciding with the first HOLDOFF cycle is too close to the
      // NAK to be treated as a new frame.
      S_HOLDOFF: if (sie_sof_irq_i && !hold_arm_q) state_d = S_START;
      default:                      state_d = S_IDLE;
    endcase
  end

  assign sie_start_o  = (state_q == S_START);
  assign busy_o       = (state_q != S_IDLE);
  assign ch0_done_o   = (state_q == S_EVAL) && fin && !cur_ch_q;
  assign ch1_done_o   = (state_q == S_EVAL) && fin &&  cur_ch_q;
  assign ch0_status_o = ch0_done_o ? fin_status : st0_q;
  assign ch1_status_o = ch1_done_o ? fin_status : st1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q             <= S_IDLE;
      cur_ch_q            <= 1'b0;
      last_ch_q           <= 1'b1;
      toggle_q            <= 2'b00;
      nak_cnt_q           <= 4'd0;
      err_cnt_q           <= 2'd0;
      rsp_pid_q           <= 8'h00;
      rsp_err_q           <= 1'b0;
      hold_arm_q          <= 1'b0;
      st0_q               <= 2'b00;
      st1_q               <= 2'b00;
      sie_token_pid_o     <= 8'h00;
      sie_token_data_o    <= 11'h000;
      sie_tx_count_o      <= 16'h0000;
      sie_data_idx_o      <= 1'b0;
      sie_in_transfer_o   <= 1'b0;
      sie_resp_expected_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_arm_q <= (state_q == S_EVAL) && (state_d == S_HOLDOFF);

      if (state_q == S_IDLE && grant) begin
        cur_ch_q            <= grant_ch;
        last_ch_q           <= grant_ch;
        nak_cnt_q           <= 4'd0;
        err_cnt_q           <= 2'd0;
        sie_token_pid_o     <= grant_ch ? ch1_pid_i   : ch0_pid_i;
        sie_token_data_o    <= grant_ch ? ch1_token_i : ch0_token_i;
        sie_tx_count_o      <= grant_ch ? ch1_len_i   : ch0_len_i;
        sie_in_transfer_o   <= grant_ch ? ch1_in_i    : ch0_in_i;
        sie_data_idx_o      <= toggle_q[grant_ch];
        sie_resp_expected_o <= 1'b1;
      end

      if (state_q == S_WAIT && wait_done) begin
        rsp_pid_q <= sie_rx_resp_pid_i;
        rsp_err_q <= sie_rx_resp_timeout_i | sie_rx_crc_err_i;
      end

      if (state_q == S_EVAL) begin
        if (rsp == R_NAK && nak_cnt_q != 4'hF) nak_cnt_q <= nak_cnt_q + 4'd1;
        if (rsp == R_ERR && err_cnt_q != 2'h3) err_cnt_q <= err_cnt_q + 2'd1;
        if (fin) begin
          if (cur_ch_q) st1_q <= fin_status;
          else          st0_q <= fin_status;
        end
      end

      // The response-driven update beats a software clear for the channel in EVAL.
      for (int n = 0; n < 2; n++) begin
        if (state_q == S_EVAL && int'(cur_ch_q) == n) begin
          if (rsp == R_OK) toggle_q[n] <= toggle_new;
        end else if (toggle_clr[n]) begin
          toggle_q[n] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_usbh_xfer_sched.sv
// Bench for usbh_xfer_sched: directed transfers with a scoreboard of expected SIE starts and completions.
// Stimulus acts as both channel clients and the SIE; a negedge monitor pops and compares.
// Ends with a single pass-count summary line.
`timescale 1ns/1ps
module tb_usbh_xfer_sched;

  localparam logic [7:0] OUT = 8'hE1, IN = 8'h69, SETUP = 8'h2D;
  localparam logic [7:0] ACK = 8'hD2, NAK = 8'h5A, STALL = 8'h1E, D0 = 8'hC3, D1 = 8'h4B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ch0_req, ch0_in, ch0_clr, ch0_done;
  logic [7:0]  ch0_pid;
  logic [10:0] ch0_tok;
  logic [15:0] ch0_len;
  logic [1:0]  ch0_st;
  logic        ch1_req, ch1_in, ch1_clr, ch1_done;
  logic [7:0]  ch1_pid;
  logic [10:0] ch1_tok;
  logic [15:0] ch1_len;
  logic [1:0]  ch1_st;
  logic        s_start, s_idx, s_in, s_resp_exp, busy;
  logic [7:0]  s_pid;
  logic [10:0] s_tok;
  logic [15:0] s_cnt;
  logic        s_ack, s_txd, s_rxd, s_crc, s_tmo, s_sof;
  logic [7:0]  s_rpid;

  usbh_xfer_sched dut (
    .clk_i(clk), .rst_i(rst),
    .ch0_req_i(ch0_req), .ch0_pid_i(ch0_pid), .ch0_token_i(ch0_tok), .ch0_in_i(ch0_in),
    .ch0_len_i(ch0_len), .ch0_toggle_clr_i(ch0_clr), .ch0_done_o(ch0_done), .ch0_status_o(ch0_st),
    .ch1_req_i(ch1_req), .ch1_pid_i(ch1_pid), .ch1_token_i(ch1_tok), .ch1_in_i(ch1_in),
    .ch1_len_i(ch1_len), .ch1_toggle_clr_i(ch1_clr), .ch1_done_o(ch1_done), .ch1_status_o(ch1_st),
    .sie_start_o(s_start), .sie_token_pid_o(s_pid), .sie_token_data_o(s_tok),
    .sie_tx_count_o(s_cnt), .sie_data_idx_o(s_idx), .sie_in_transfer_o(s_in),
    .sie_resp_expected_o(s_resp_exp), .sie_req_ack_i(s_ack), .sie_tx_done_i(s_txd),
    .sie_rx_done_i(s_rxd), .sie_rx_crc_err_i(s_crc), .sie_rx_resp_timeout_i(s_tmo),
    .sie_rx_resp_pid_i(s_rpid), .sie_sof_irq_i(s_sof), .busy_o(busy)
  );

  typedef struct packed {
    logic [7:0]  pid;
    logic [10:0] tok;
    logic [15:0] len;
    logic        idx;
    logic        in_;
  } start_t;
  typedef struct packed {
    logic       ch;
    logic [1:0] st;
  } done_t;

  start_t exp_start[$];
  done_t  exp_done[$];
  start_t es, gs;
  done_t  ed, gd;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, want);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event seen or missing, required the opposite", name);
  endtask

  // Monitor: compares every new SIE start and every completion against the scoreboard.
  logic start_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      start_prev = 1'b0;
    end else begin
      if (s_start && !start_prev) begin
        if (exp_start.size() == 0) fail_now("unexpected_start");
        else begin
          es = exp_start.pop_front();
          gs = '{pid: s_pid, tok: s_tok, len: s_cnt, idx: s_idx, in_: s_in};
          chk("start_fields", 64'(gs), 64'(es));
          chk("resp_expected", 64'(s_resp_exp), 64'd1);
        end
      end
      start_prev = s_start;
      if (ch0_done && ch1_done) fail_now("both_done");
      else if (ch0_done || ch1_done) begin
        if (exp_done.size() == 0) fail_now("unexpected_done");
        else begin
          ed = exp_done.pop_front();
          gd = '{ch: ch1_done, st: (ch1_done ? ch1_st : ch0_st)};
          chk("done_ch_status", 64'(gd), 64'(ed));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_start(input logic [7:0] pid, input logic [10:0] tok, input logic [15:0] len,
                            input logic idx, input logic in_);
    exp_start.push_back('{pid: pid, tok: tok, len: len, idx: idx, in_: in_});
  endtask

  task automatic push_done(input logic ch, input logic [1:0] st);
    exp_done.push_back('{ch: ch, st: st});
  endtask

  task automatic set_ch(input logic ch, input logic [7:0] pid, input logic [10:0] tok,
                        input logic [15:0] len, input logic in_);
    if (ch) begin ch1_pid = pid; ch1_tok = tok; ch1_len = len; ch1_in = in_; end
    else    begin ch0_pid = pid; ch0_tok = tok; ch0_len = len; ch0_in = in_; end
  endtask

  task automatic wait_start();
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (s_start) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) fail_now("start_timeout");
  endtask

  // Plays the SIE for one attempt; returns in the EVAL cycle.
  // kind 0: rx_done with pid, 1: rx_done with CRC error, 2: response timeout.
  task automatic serve(input int ack_dly, input int kind, input logic [7:0] pid);
    wait_start();
    repeat (ack_dly) tick();
    if (ack_dly > 0) chk("start_held", 64'(s_start), 64'd1);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    chk("start_dropped", 64'(s_start), 64'd0);
    s_txd = 1'b1;          // tx completion alone must not end the transfer
    tick();
    s_txd = 1'b0;
    chk("tx_done_no_finish", 64'(ch0_done | ch1_done), 64'd0);
    case (kind)
      0:       begin s_rxd = 1'b1; s_rpid = pid; end
      1:       begin s_rxd = 1'b1; s_crc = 1'b1; s_rpid = pid; end
      default: s_tmo = 1'b1;
    endcase
    tick();
    s_rxd = 1'b0; s_crc = 1'b0; s_tmo = 1'b0; s_rpid = 8'h00;
  endtask

  task automatic finish(input logic ch);
    chk("done_pulse", 64'(ch ? ch1_done : ch0_done), 64'd1);
    if (ch) ch1_req = 1'b0; else ch0_req = 1'b0;
    tick();
    chk("done_one_cycle", 64'(ch ? ch1_done : ch0_done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  task automatic retry_gap();
    chk("no_done_on_retry", 64'(ch0_done | ch1_done), 64'd0);
    tick();
    chk("retry_start", 64'(s_start), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {ch0_req, ch0_in, ch0_clr, ch1_req, ch1_in, ch1_clr} = '0;
    ch0_pid = 8'h00; ch0_tok = 11'h0; ch0_len = 16'h0;
    ch1_pid = 8'h00; ch1_tok = 11'h0; ch1_len = 16'h0;
    {s_ack, s_txd, s_rxd, s_crc, s_tmo, s_sof} = '0;
    s_rpid = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(s_start), 64'd0);
    chk("rst_done", 64'({ch0_done, ch1_done}), 64'd0);
    chk("rst_status", 64'({ch0_st, ch1_st}), 64'd0);
    chk("rst_sie_fields", 64'({s_pid, s_tok, s_cnt, s_idx, s_in, s_resp_exp}), 64'd0);

    // Arbitration: ch0, ch1, ch0 on ties, then ch1 alone.
    set_ch(0, OUT, 11'h001, 16'd8, 1'b0);
    set_ch(1, OUT, 11'h002, 16'd8, 1'b0);
    push_start(OUT, 11'h001, 16'd8, 1'b0, 1'b0); push_done(0, 2'b00);
    push_start(OUT, 11'h002, 16'd8, 1'b0, 1'b0); push_done(1, 2'b00);
    push_start(OUT, 11'h001, 16'd8, 1'b1, 1'b0); push_done(0, 2'b00);
    push_start(OUT, 11'h002, 16'd8, 1'b1, 1'b0); push_done(1, 2'b00);
    ch0_req = 1'b1; ch1_req = 1'b1;
    serve(0, 0, ACK); finish(0); ch0_req = 1'b1;
    serve(0, 0, ACK); finish(1); ch1_req = 1'b1;
    serve(0, 0, ACK); finish(0);
    serve(0, 0, ACK); finish(1);

    // ch0 OUT acked after two-cycle ack delay (toggle 0 -> 1).
    set_ch(0, OUT, 11'h123, 16'd64, 1'b0);
    push_start(OUT, 11'h123, 16'd64, 1'b0, 1'b0); push_done(0, 2'b00);
    ch0_req = 1'b1;
    serve(2, 0, ACK); finish(0);

    // Four timeouts back-to-back -> error status, toggle stays 1.
    set_ch(0, OUT, 11'h124, 16'd32, 1'b0);
    for (int k = 0; k < 4; k++) push_start(OUT, 11'h124, 16'd32, 1'b1, 1'b0);
    push_done(0, 2'b11);
    ch0_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serve(0, 2, 8'h00);
      if (k < 3) retry_gap(); else finish(0);
    end

    // Next ch0 transfer uses DATA1 (toggle -> 0 after ACK).
    set_ch(0, OUT, 11'h123, 16'd64, 1'b0);
    push_start(OUT, 11'h123, 16'd64, 1'b1, 1'b0); push_done(0, 2'b00);
    ch0_req = 1'b1;
    serve(0, 0, ACK); finish(0);

    // ch1 IN NAKed 16 times, each retry only after an SOF.
    set_ch(1, IN, 11'h055, 16'd0, 1'b1);
    for (int k = 0; k < 16; k++) push_start(IN, 11'h055, 16'd0, 1'b0, 1'b1);
    push_done(1, 2'b10);
    ch1_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      serve(0, 0, NAK);
      if (k < 15) begin
        chk("no_done_on_nak", 64'(ch1_done), 64'd0);
        if (k == 0) s_sof = 1'b1;   // SOF in the entry cycle is ignored
        tick();
        s_sof = 1'b0;
        for (int j = 0; j < 3; j++) begin
          chk("holdoff_no_start", 64'({busy, s_start}), 64'b10);
          tick();
        end
        s_sof = 1'b1;
        tick();
        s_sof = 1'b0;
      end else begin
        finish(1);
      end
    end

    // ch1 IN DATA0 -> toggle 1; IN DATA1 -> toggle 0; STALL keeps toggle 0.
    set_ch(1, IN, 11'h056, 16'd0, 1'b1);
    push_start(IN, 11'h056, 16'd0, 1'b0, 1'b1); push_done(1, 2'b00);
    push_start(IN, 11'h056, 16'd0, 1'b1, 1'b1); push_done(1, 2'b00);
    push_start(IN, 11'h056, 16'd0, 1'b0, 1'b1); push_done(1, 2'b01);
    ch1_req = 1'b1; serve(0, 0, D0);    finish(1);
    ch1_req = 1'b1; serve(0, 0, D1);    finish(1);
    ch1_req = 1'b1; serve(0, 0, STALL); finish(1);

    // SETUP ack -> toggle 1, then software clear -> 0.
    set_ch(1, SETUP, 11'h057, 16'd8, 1'b0);
    push_start(SETUP, 11'h057, 16'd8, 1'b0, 1'b0); push_done(1, 2'b00);
    ch1_req = 1'b1; serve(0, 0, ACK); finish(1);
    ch1_clr = 1'b1; tick(); ch1_clr = 1'b0;

    // CRC error, then unknown PID, then ACK: three DATA0 attempts, toggle -> 1.
    set_ch(1, OUT, 11'h058, 16'd4, 1'b0);
    for (int k = 0; k < 3; k++) push_start(OUT, 11'h058, 16'd4, 1'b0, 1'b0);
    push_done(1, 2'b00);
    ch1_req = 1'b1;
    serve(0, 1, ACK);   retry_gap();
    serve(0, 0, 8'h00); retry_gap();
    serve(0, 0, ACK);   finish(1);

    // IN DATA0 with a clear in the EVAL cycle: update wins, toggle -> 1.
    set_ch(1, IN, 11'h059, 16'd0, 1'b1);
    push_start(IN, 11'h059, 16'd0, 1'b1, 1'b1); push_done(1, 2'b00);
    ch1_req = 1'b1; serve(0, 0, D0);
    ch1_clr = 1'b1; finish(1); ch1_clr = 1'b0;
    set_ch(1, OUT, 11'h05A, 16'd2, 1'b0);
    push_start(OUT, 11'h05A, 16'd2, 1'b1, 1'b0); push_done(1, 2'b00);
    ch1_req = 1'b1; serve(0, 0, ACK); finish(1);

    // Reset while waiting for the response: abort, no done pulse.
    set_ch(0, OUT, 11'h0AA, 16'd2, 1'b0);
    push_start(OUT, 11'h0AA, 16'd2, 1'b0, 1'b0);
    ch0_req = 1'b1;
    wait_start();
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    rst = 1'b1; ch0_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_wait_busy", 64'(busy), 64'd0);
    chk("rst_wait_start", 64'(s_start), 64'd0);
    chk("rst_wait_done", 64'({ch0_done, ch1_done}), 64'd0);
    repeat (3) begin
      tick();
      chk("rst_stays_idle", 64'({busy, ch0_done, ch1_done}), 64'd0);
    end

    // Round-robin pointer reset: tie goes to ch0 again.
    set_ch(0, OUT, 11'h0B0, 16'd1, 1'b0);
    set_ch(1, OUT, 11'h0B1, 16'd1, 1'b0);
    push_start(OUT, 11'h0B0, 16'd1, 1'b0, 1'b0); push_done(0, 2'b00);
    push_start(OUT, 11'h0B1, 16'd1, 1'b0, 1'b0); push_done(1, 2'b00);
    ch0_req = 1'b1; ch1_req = 1'b1;
    serve(0, 0, ACK); finish(0);
    serve(0, 0, ACK); finish(1);

    repeat (4) tick();
    chk("start_queue_drained", 64'(exp_start.size()), 64'd0);
    chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
